// File: rtl/uart_pkg.sv
// Shared types for the UART echo path.
// Character width default and TX sequencer states.
package uart_pkg;

    localparam int PAYLOAD_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is read combinationally.
// Power-of-two depth so pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is kept.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffers received UART characters and replays them to the transmitter.
// Break rising edge flushes the queue; dropped characters set a sticky flag.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int DEPTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_break,
    input  logic                    tx_busy,
    input  logic                    clr_ovf,
    output logic [PAYLOAD_BITS-1:0] tx_data,
    output logic                    tx_en,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic                    overflow
);

    tx_state_e               state;
    logic                    break_q;
    logic                    flush;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [PAYLOAD_BITS-1:0] head;

    assign flush = rx_break & ~break_q;
    assign push  = rx_valid & ~rx_break;
    // Flush wins over a pop so nothing from a discarded queue reaches tx_data.
    assign pop   = (state == IDLE) & ~fifo_empty & ~tx_busy & ~flush;
    assign drop  = push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= LOAD;
                        tx_en   <= 1'b1;
                        tx_data <= head;
                    end
                end
                LOAD: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            break_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            break_q <= rx_break;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
